clk_div_multi: RTL and testbench

//  Parametrised multi-channel clock divider / tick generator. Each channel divides CLK by a

---
 rtl/clk_div_multi_if.sv | 27 ++
 rtl/clk_div_multi.sv | 78 +++++++
 tb/tb_clk_div_multi.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_multi_if.sv
// Control and output bundle for the multi-channel clock divider.
// The master drives run/mode/divisor controls; the slave returns the divided outputs.
interface clk_div_multi_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
);
   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] mode;
   logic              sync;
   logic              div_wr;
   logic [SEL_W-1:0]  div_sel;
   logic [CNT_W-1:0]  div_data;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;

   modport master (
      output en, mode, sync, div_wr, div_sel, div_data,
      input  clk_out, tick
   );

   modport slave (
      input  en, mode, sync, div_wr, div_sel, div_data,
      output clk_out, tick
   );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel emits a 50% square wave or a
// one-cycle tick every DIV cycles, with divisor changes deferred to period boundaries.
module clk_div_multi #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int DIV_DEFAULT = 50000
) (
   input logic            clk,
   input logic            rst_n,
   clk_div_multi_if.slave bus
);
   localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DEFAULT);

   logic [CNT_W-1:0]  cnt      [NUM_CH];
   logic [CNT_W-1:0]  div_q    [NUM_CH];
   logic [CNT_W-1:0]  shadow   [NUM_CH];
   logic [CNT_W-1:0]  div_next [NUM_CH];
   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] clk_out_q;
   logic [NUM_CH-1:0] tick_q;
   logic [NUM_CH-1:0] wr_hit;
   logic [NUM_CH-1:0] tc;
   logic [NUM_CH-1:0] apply_div;
   logic [CNT_W-1:0]  wr_val;

   // A write landing on the same edge as a boundary wins over any older pending value,
   // so it must be folded into the divisor chosen for that boundary.
   always_comb begin
      wr_val = (bus.div_data == '0) ? CNT_W'(1) : bus.div_data;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_hit[i]    = bus.div_wr && (int'(bus.div_sel) == i);
         tc[i]        = (cnt[i] == div_q[i] - CNT_W'(1));
         apply_div[i] = bus.sync || !bus.en[i] || tc[i];
         div_next[i]  = wr_hit[i] ? wr_val : (pend[i] ? shadow[i] : div_q[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend      <= '0;
         clk_out_q <= '0;
         tick_q    <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]    <= '0;
            div_q[i]  <= DIV_INIT;
            shadow[i] <= DIV_INIT;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (apply_div[i]) begin
               div_q[i] <= div_next[i];
               pend[i]  <= 1'b0;
            end else if (wr_hit[i]) begin
               shadow[i] <= wr_val;
               pend[i]   <= 1'b1;
            end

            // Each output is forced low outside its own mode, so a mode switch takes effect next edge.
            if (bus.sync || !bus.en[i]) begin
               cnt[i]       <= '0;
               clk_out_q[i] <= 1'b0;
               tick_q[i]    <= 1'b0;
            end else if (tc[i]) begin
               cnt[i]       <= '0;
               clk_out_q[i] <= !bus.mode[i] && !clk_out_q[i];
               tick_q[i]    <= bus.mode[i];
            end else begin
               cnt[i]       <= cnt[i] + CNT_W'(1);
               clk_out_q[i] <= !bus.mode[i] && clk_out_q[i];
               tick_q[i]    <= 1'b0;
            end
         end
      end
   end

   assign bus.clk_out = clk_out_q;
   assign bus.tick    = tick_q;
endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: expected outputs are queued with each stimulus step
// and compared one edge later against the registered outputs.
module tb_clk_div_multi;
   localparam int N       = 3;
   localparam int W       = 16;
   localparam int DIV_DEF = 500;

   typedef struct {
      string        tag;
      logic [N-1:0] clk_exp;
      logic [N-1:0] tick_exp;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   k;

   clk_div_multi_if #(.NUM_CH(N), .CNT_W(W)) bus ();

   clk_div_multi #(.NUM_CH(N), .CNT_W(W), .DIV_DEFAULT(DIV_DEF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic phase(input int edges, input int div);
      return ((edges / div) % 2) == 1;
   endfunction

   task automatic compare(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input string tag, input logic [N-1:0] en_v, input logic [N-1:0] mode_v,
                                 input logic sync_v, input logic wr_v, input logic [1:0] sel_v,
                                 input logic [W-1:0] data_v, input logic [N-1:0] exp_clk,
                                 input logic [N-1:0] exp_tick);
      exp_t e;
      bus.en       = en_v;
      bus.mode     = mode_v;
      bus.sync     = sync_v;
      bus.div_wr   = wr_v;
      bus.div_sel  = sel_v;
      bus.div_data = data_v;
      e.tag      = tag;
      e.clk_exp  = exp_clk;
      e.tick_exp = exp_tick;
      sb_q.push_back(e);
   endtask

   task automatic check_output();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         compare({e.tag, " clk_out"}, bus.clk_out, e.clk_exp);
         compare({e.tag, " tick"}, bus.tick, e.tick_exp);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.en       = '0;
      bus.mode     = '0;
      bus.sync     = 1'b0;
      bus.div_wr   = 1'b0;
      bus.div_sel  = '0;
      bus.div_data = '0;
      repeat (2) @(posedge clk);
      #1;
      compare("reset clk_out", bus.clk_out, '0);
      compare("reset tick", bus.tick, '0);
      rst_n = 1'b1;

      // Default divisor: first toggle on the DIV-th enabled edge, then async reset mid-high.
      for (int i = 1; i <= 600; i++) begin
         apply_stimulus($sformatf("t1 run e%0d", i), 3'b001, 3'b000, 1'b0, 1'b0, 2'd0, 16'd0,
                        {2'b00, i >= DIV_DEF}, 3'b000);
         check_output();
      end
      rst_n = 1'b0;
      #2;
      compare("t1 async clk_out", bus.clk_out, 3'b000);
      compare("t1 async tick", bus.tick, 3'b000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 1; i <= 1500; i++) begin
         apply_stimulus($sformatf("t1 period e%0d", i), 3'b001, 3'b000, 1'b0, 1'b0, 2'd0, 16'd0,
                        {2'b00, phase(i, DIV_DEF)}, 3'b000);
         check_output();
      end

      // DIV=1 gives CLK/2, DIV=3 gives a 6-cycle period.
      apply_stimulus("t2 stop", 3'b000, 3'b000, 1'b0, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000);
      check_output();
      apply_stimulus("t2 wr1", 3'b000, 3'b000, 1'b0, 1'b1, 2'd0, 16'd1, 3'b000, 3'b000);
      check_output();
      for (int j = 1; j <= 4; j++) begin
         apply_stimulus($sformatf("t2 div1 e%0d", j), 3'b001, 3'b000, 1'b0, 1'b0, 2'd0, 16'd0,
                        {2'b00, phase(j, 1)}, 3'b000);
         check_output();
      end
      apply_stimulus("t2 stop2", 3'b000, 3'b000, 1'b0, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000);
      check_output();
      apply_stimulus("t2 wr3", 3'b000, 3'b000, 1'b0, 1'b1, 2'd0, 16'd3, 3'b000, 3'b000);
      check_output();
      for (int j = 1; j <= 12; j++) begin
         apply_stimulus($sformatf("t2 div3 e%0d", j), 3'b001, 3'b000, 1'b0, 1'b0, 2'd0, 16'd0,
                        {2'b00, phase(j, 3)}, 3'b000);
         check_output();
      end

      // Channel 1 tick mode, DIV=4: ticks after enabled edges 3, 7, 11.
      apply_stimulus("t3 setup", 3'b000, 3'b010, 1'b0, 1'b1, 2'd1, 16'd4, 3'b000, 3'b000);
      check_output();
      for (int j = 0; j <= 11; j++) begin
         apply_stimulus($sformatf("t3 tick e%0d", j), 3'b010, 3'b010, 1'b0, 1'b0, 2'd0, 16'd0,
                        3'b000, {1'b0, (j % 4) == 3, 1'b0});
         check_output();
      end

      // Two writes inside a period: the current period ends on time, the last write wins.
      apply_stimulus("t4 cnt1", 3'b010, 3'b010, 1'b0, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000);
      check_output();
      apply_stimulus("t4 wr9", 3'b010, 3'b010, 1'b0, 1'b1, 2'd1, 16'd9, 3'b000, 3'b000);
      check_output();
      apply_stimulus("t4 wr10", 3'b010, 3'b010, 1'b0, 1'b1, 2'd1, 16'd10, 3'b000, 3'b000);
      check_output();
      apply_stimulus("t4 tc", 3'b010, 3'b010, 1'b0, 1'b0, 2'd0, 16'd0, 3'b000, 3'b010);
      check_output();
      for (int j = 1; j <= 10; j++) begin
         apply_stimulus($sformatf("t4 div10 e%0d", j), 3'b010, 3'b010, 1'b0, 1'b0, 2'd0, 16'd0,
                        3'b000, {1'b0, j == 10, 1'b0});
         check_output();
      end

      // SYNC aligns channels and applies a pending divisor.
      apply_stimulus("t5 stop", 3'b000, 3'b000, 1'b0, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000);
      check_output();
      apply_stimulus("t5 wr0", 3'b000, 3'b000, 1'b0, 1'b1, 2'd0, 16'd5, 3'b000, 3'b000);
      check_output();
      apply_stimulus("t5 wr1", 3'b000, 3'b000, 1'b0, 1'b1, 2'd1, 16'd6, 3'b000, 3'b000);
      check_output();
      for (int j = 1; j <= 7; j++) begin
         apply_stimulus($sformatf("t5 pre e%0d", j), 3'b011, 3'b000, 1'b0, 1'b0, 2'd0, 16'd0,
                        {1'b0, phase(j, 6), phase(j, 5)}, 3'b000);
         check_output();
      end
      apply_stimulus("t5 pend", 3'b011, 3'b000, 1'b0, 1'b1, 2'd0, 16'd3, 3'b011, 3'b000);
      check_output();
      apply_stimulus("t5 sync", 3'b011, 3'b000, 1'b1, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000);
      check_output();
      for (k = 1; k <= 27; k++) begin
         apply_stimulus($sformatf("t5 post e%0d", k), 3'b011, 3'b000, 1'b0, 1'b0, 2'd0, 16'd0,
                        {1'b0, phase(k, 6), phase(k, 3)}, 3'b000);
         check_output();
      end

      // EN drop while high, DIV_DATA=0, out-of-range select, tick mode with DIV=1.
      k = 28;
      apply_stimulus("t6 en drop", 3'b010, 3'b000, 1'b0, 1'b0, 2'd0, 16'd0,
                     {1'b0, phase(k, 6), 1'b0}, 3'b000);
      check_output();
      for (int j = 1; j <= 6; j++) begin
         k++;
         apply_stimulus($sformatf("t6 reen e%0d", j), 3'b011, 3'b000, 1'b0, 1'b0, 2'd0, 16'd0,
                        {1'b0, phase(k, 6), phase(j, 3)}, 3'b000);
         check_output();
      end
      k++;
      apply_stimulus("t6 wr0", 3'b010, 3'b000, 1'b0, 1'b1, 2'd0, 16'd0,
                     {1'b0, phase(k, 6), 1'b0}, 3'b000);
      check_output();
      for (int j = 1; j <= 4; j++) begin
         k++;
         apply_stimulus($sformatf("t6 div0 e%0d", j), 3'b011, 3'b000, 1'b0, 1'b0, 2'd0, 16'd0,
                        {1'b0, phase(k, 6), phase(j, 1)}, 3'b000);
         check_output();
      end
      k++;
      apply_stimulus("t6 badsel", 3'b011, 3'b000, 1'b0, 1'b1, 2'd3, 16'd2,
                     {1'b0, phase(k, 6), phase(5, 1)}, 3'b000);
      check_output();
      for (int j = 6; j <= 17; j++) begin
         k++;
         apply_stimulus($sformatf("t6 after e%0d", j), 3'b011, 3'b000, 1'b0, 1'b0, 2'd0, 16'd0,
                        {1'b0, phase(k, 6), phase(j, 1)}, 3'b000);
         check_output();
      end
      for (int j = 1; j <= 4; j++) begin
         k++;
         apply_stimulus($sformatf("t6 tick1 e%0d", j), 3'b011, 3'b001, 1'b0, 1'b0, 2'd0, 16'd0,
                        {1'b0, phase(k, 6), 1'b0}, 3'b001);
         check_output();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
